// File: rtl/regfile_dbg_if.sv
// rtl/regfile_dbg_if.sv - register file access and debug dump bus
interface regfile_dbg_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             we;
  logic             dbg_start;
  logic             dbg_ready;
  logic             dbg_valid;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;
  logic             dbg_busy;
  logic             dbg_done;

  modport master (
    output ra1, ra2, wa, wd, we, dbg_start, dbg_ready,
    input  rd1, rd2, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
  );

  modport slave (
    input  ra1, ra2, wa, wd, we, dbg_start, dbg_ready,
    output rd1, rd2, dbg_valid, dbg_addr, dbg_data, dbg_busy, dbg_done
  );
endinterface

// File: rtl/regfile_dbg.sv
// rtl/regfile_dbg.sv - DEPTH x WIDTH register file with debug dump engine
module regfile_dbg #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  regfile_dbg_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] regs_q [DEPTH];
  state_t           state_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             wr_en;
  logic [AW-1:0]    nxt_idx_d;
  logic [WIDTH-1:0] nxt_data_d;

  // Value seen at address a: zero register wins, then optional forwarding of this cycle's write.
  function automatic logic [WIDTH-1:0] view(input logic [AW-1:0] a, input logic fwd,
                                            input logic w_en, input logic [AW-1:0] w_a,
                                            input logic [WIDTH-1:0] w_d,
                                            input logic [WIDTH-1:0] stored);
    if (ZERO_R0 != 0 && a == '0) return '0;
    if (fwd && w_en && w_a == a) return w_d;
    return stored;
  endfunction

  assign wr_en = bus.we && !(ZERO_R0 != 0 && bus.wa == '0);

  // Combinational read ports.
  always_comb begin
    bus.rd1 = view(bus.ra1, BYPASS != 0, bus.we, bus.wa, bus.wd, regs_q[bus.ra1]);
    bus.rd2 = view(bus.ra2, BYPASS != 0, bus.we, bus.wa, bus.wd, regs_q[bus.ra2]);
  end

  // Next beat: index 0 when starting, otherwise the successor; data is write-first.
  always_comb begin
    nxt_idx_d  = (state_q == S_IDLE) ? '0 : idx_q + AW'(1);
    nxt_data_d = view(nxt_idx_d, 1'b1, bus.we, bus.wa, bus.wd, regs_q[nxt_idx_d]);
  end

  // Register array: cleared by reset, written on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wa] <= bus.wd;
    end
  end

  // Dump FSM with registered handshake outputs; a beat is held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.dbg_start) begin
            state_q <= S_SEND;
            idx_q   <= nxt_idx_d;
            data_q  <= nxt_data_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SEND: begin
          if (bus.dbg_ready) begin
            if (idx_q == AW'(DEPTH - 1)) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= nxt_idx_d;
              data_q <= nxt_data_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dbg_valid = valid_q;
  assign bus.dbg_busy  = busy_q;
  assign bus.dbg_done  = done_q;
  assign bus.dbg_addr  = idx_q;
  assign bus.dbg_data  = data_q;

endmodule
